// File: rtl/fetch_pc_gen.sv
// Fetch PC generator with a small fetch queue recording per-fetch predictions.
// Picks next fetch PC from redirects (exception > mispredict > prediction).
//
// Ports:
//   clk, rstn                   clock, async active-low reset
//   ifReady                     I-cache accepts ifPC this cycle
//   pdPC, pdBranch, pdReason    predictor result for the current ifPC
//   exVld, exWrong, exPCTar     EX branch resolution / mispredict target
//   excVld, excPC               exception / ertn redirect
//   idReady                     decode consumes the queue head
//   ifVld, ifPC                 fetch request to I-cache and predictor
//   flush                       one-cycle pulse after any redirect
//   fqVld, fqPC, fqBranch,
//   fqReason, fqTarget          queue head and its recorded prediction

module fetch_pc_gen #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h1C000000,
    parameter int                    FQ_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  ifReady,
    input  logic [ADDR_WIDTH-1:0] pdPC,
    input  logic                  pdBranch,
    input  logic                  pdReason,
    input  logic                  exVld,
    input  logic                  exWrong,
    input  logic [ADDR_WIDTH-1:0] exPCTar,
    input  logic                  excVld,
    input  logic [ADDR_WIDTH-1:0] excPC,
    input  logic                  idReady,
    output logic                  ifVld,
    output logic [ADDR_WIDTH-1:0] ifPC,
    output logic                  flush,
    output logic                  fqVld,
    output logic [ADDR_WIDTH-1:0] fqPC,
    output logic                  fqBranch,
    output logic                  fqReason,
    output logic [ADDR_WIDTH-1:0] fqTarget
);

    // FQ_DEPTH must be a power of two, at least 2.
    localparam int PW = $clog2(FQ_DEPTH);

    localparam logic [PW:0]           DEPTH_C = (PW+1)'(FQ_DEPTH);
    localparam logic [PW:0]           CNT_ONE = (PW+1)'(1);
    localparam logic [PW-1:0]         PTR_ONE = PW'(1);
    localparam logic [ADDR_WIDTH-4:0] HI_ONE  = (ADDR_WIDTH-3)'(1);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(3));

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_ifvld;
    logic                  r_flush;

    logic [ADDR_WIDTH-1:0] r_fq_pc [FQ_DEPTH];
    logic                  r_fq_br [FQ_DEPTH];
    logic                  r_fq_rs [FQ_DEPTH];
    logic [ADDR_WIDTH-1:0] r_fq_tg [FQ_DEPTH];
    logic [PW-1:0]         r_wp;
    logic [PW-1:0]         r_rp;
    logic [PW:0]           r_cnt;

    logic                  w_accept;
    logic                  w_mis;
    logic                  w_redir;
    logic [ADDR_WIDTH-1:0] w_tgt;
    logic [ADDR_WIDTH-1:0] w_tgt_al;
    logic                  w_fqvld;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic [PW:0]           w_cnt_nxt;
    logic [ADDR_WIDTH-1:0] w_seq_pc;
    logic [ADDR_WIDTH-1:0] w_nxt_pc;

    // A mispredict during BOOT refers to nothing we fetched: ignore it.
    assign w_accept = r_ifvld & ifReady;
    assign w_mis    = exVld & exWrong & (r_state != S_BOOT);
    assign w_redir  = excVld | w_mis;
    assign w_tgt    = excVld ? excPC : exPCTar;
    assign w_tgt_al = w_tgt & ALIGN_MASK;

    // A redirect kills the queue, so same-cycle push/pop are dropped.
    assign w_fqvld = (r_cnt != '0);
    assign w_full  = (r_cnt == DEPTH_C);
    assign w_pop   = w_fqvld & idReady & ~w_redir;
    assign w_push  = w_accept & ~w_redir & (~w_full | w_pop);

    // Sequential fetch moves to the next 8-byte pair; wraps silently.
    assign w_seq_pc = {r_pc[ADDR_WIDTH-1:3] + HI_ONE, 3'b000};
    assign w_nxt_pc = pdBranch ? pdPC : w_seq_pc;

    always_comb begin
        w_cnt_nxt = r_cnt;
        case ({w_push, w_pop})
            2'b10:   w_cnt_nxt = r_cnt + CNT_ONE;
            2'b01:   w_cnt_nxt = r_cnt - CNT_ONE;
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    // Fetch control. HOLD is chosen from the post-edge count so a
    // request is never offered while the queue has no free slot.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_BOOT;
            r_pc    <= RESET_PC;
            r_ifvld <= 1'b0;
            r_flush <= 1'b0;
        end else begin
            r_flush <= w_redir;
            if (w_redir) begin
                r_pc    <= w_tgt_al;
                r_state <= S_FETCH;
                r_ifvld <= 1'b1;
            end else begin
                case (r_state)
                    S_BOOT: begin
                        r_state <= S_FETCH;
                        r_ifvld <= 1'b1;
                    end
                    S_FETCH: begin
                        if (w_push) begin
                            r_pc <= w_nxt_pc;
                        end
                        if (w_cnt_nxt == DEPTH_C) begin
                            r_state <= S_HOLD;
                            r_ifvld <= 1'b0;
                        end else begin
                            r_ifvld <= 1'b1;
                        end
                    end
                    S_HOLD: begin
                        if (w_cnt_nxt != DEPTH_C) begin
                            r_state <= S_FETCH;
                            r_ifvld <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_BOOT;
                        r_ifvld <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Fetch queue: circular buffer with explicit occupancy count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < FQ_DEPTH; i++) begin
                r_fq_pc[i] <= '0;
                r_fq_br[i] <= 1'b0;
                r_fq_rs[i] <= 1'b0;
                r_fq_tg[i] <= '0;
            end
        end else if (w_redir) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_fq_pc[r_wp] <= r_pc;
                r_fq_br[r_wp] <= pdBranch;
                r_fq_rs[r_wp] <= pdReason;
                r_fq_tg[r_wp] <= pdPC;
                r_wp          <= r_wp + PTR_ONE;
            end
            if (w_pop) begin
                r_rp <= r_rp + PTR_ONE;
            end
            r_cnt <= w_cnt_nxt;
        end
    end

    assign ifVld    = r_ifvld;
    assign ifPC     = r_pc;
    assign flush    = r_flush;

    // Head fields are forced to zero when the queue is empty.
    assign fqVld    = w_fqvld;
    assign fqPC     = w_fqvld ? r_fq_pc[r_rp] : '0;
    assign fqBranch = w_fqvld & r_fq_br[r_rp];
    assign fqReason = w_fqvld & r_fq_rs[r_rp];
    assign fqTarget = w_fqvld ? r_fq_tg[r_rp] : '0;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Testbench for fetch_pc_gen: directed vector table, random run against
// a queue-based reference model, and an asynchronous reset check.

module tb_fetch_pc_gen;

    localparam int DEPTH = 4;
    localparam logic [31:0] RST_PC = 32'h1C000000;

    logic        clk;
    logic        rstn;
    logic        ifReady;
    logic [31:0] pdPC;
    logic        pdBranch;
    logic        pdReason;
    logic        exVld;
    logic        exWrong;
    logic [31:0] exPCTar;
    logic        excVld;
    logic [31:0] excPC;
    logic        idReady;
    logic        ifVld;
    logic [31:0] ifPC;
    logic        flush;
    logic        fqVld;
    logic [31:0] fqPC;
    logic        fqBranch;
    logic        fqReason;
    logic [31:0] fqTarget;

    fetch_pc_gen #(
        .ADDR_WIDTH(32),
        .RESET_PC  (RST_PC),
        .FQ_DEPTH  (DEPTH)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .ifReady (ifReady),
        .pdPC    (pdPC),
        .pdBranch(pdBranch),
        .pdReason(pdReason),
        .exVld   (exVld),
        .exWrong (exWrong),
        .exPCTar (exPCTar),
        .excVld  (excVld),
        .excPC   (excPC),
        .idReady (idReady),
        .ifVld   (ifVld),
        .ifPC    (ifPC),
        .flush   (flush),
        .fqVld   (fqVld),
        .fqPC    (fqPC),
        .fqBranch(fqBranch),
        .fqReason(fqReason),
        .fqTarget(fqTarget)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic        br;
        logic        rs;
        logic [31:0] tg;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;
    bit          m_boot;
    bit          m_ifvld;
    bit          m_flush;

    task automatic model_reset();
        mq.delete();
        m_pc    = RST_PC;
        m_boot  = 1;
        m_ifvld = 0;
        m_flush = 0;
    endtask

    // Next state from the inputs currently driven, applied at the edge.
    // Fetching is allowed exactly when the queue has a free slot.
    task automatic model_step();
        bit   acc;
        ent_t e;
        if (!rstn) begin
            model_reset();
        end else if (excVld || (!m_boot && exVld && exWrong)) begin
            m_pc    = (excVld ? excPC : exPCTar) & ~32'h3;
            mq.delete();
            m_boot  = 0;
            m_ifvld = 1;
            m_flush = 1;
        end else begin
            m_flush = 0;
            if (m_boot) begin
                m_boot  = 0;
                m_ifvld = 1;
            end else begin
                acc = m_ifvld && ifReady;
                if (mq.size() > 0 && idReady) void'(mq.pop_front());
                if (acc) begin
                    e.pc = m_pc;
                    e.br = pdBranch;
                    e.rs = pdReason;
                    e.tg = pdPC;
                    mq.push_back(e);
                    m_pc = pdBranch ? pdPC : ((m_pc >> 3) + 1) << 3;
                end
                m_ifvld = (mq.size() < DEPTH);
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_model(input int c);
        bit q;
        q = (mq.size() > 0);
        chk($sformatf("rnd%0d.ifVld", c), 32'(ifVld), 32'(m_ifvld));
        chk($sformatf("rnd%0d.ifPC", c), ifPC, m_pc);
        chk($sformatf("rnd%0d.flush", c), 32'(flush), 32'(m_flush));
        chk($sformatf("rnd%0d.fqVld", c), 32'(fqVld), 32'(q));
        chk($sformatf("rnd%0d.fqPC", c), fqPC, q ? mq[0].pc : 32'h0);
        chk($sformatf("rnd%0d.fqBr", c), 32'(fqBranch),
            q ? 32'(mq[0].br) : 32'h0);
        chk($sformatf("rnd%0d.fqRs", c), 32'(fqReason),
            q ? 32'(mq[0].rs) : 32'h0);
        chk($sformatf("rnd%0d.fqTg", c), fqTarget, q ? mq[0].tg : 32'h0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rstn;
        logic        ifr;
        logic        pdb;
        logic        pdr;
        logic [31:0] pdpc;
        logic        exv;
        logic        exw;
        logic [31:0] ext;
        logic        excv;
        logic [31:0] excpc;
        logic        idr;
        logic        e_v;
        logic [31:0] e_pc;
        logic        e_fl;
        logic        e_qv;
        logic [31:0] e_qpc;
        logic        e_qb;
        logic        e_qr;
        logic [31:0] e_qt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        logic r, logic ifr, logic pdb, logic pdr, logic [31:0] pdpc,
        logic exv, logic exw, logic [31:0] ext,
        logic excv, logic [31:0] excpc, logic idr,
        logic ev, logic [31:0] epc, logic efl, logic eqv,
        logic [31:0] eqpc, logic eqb, logic eqr, logic [31:0] eqt);
        vec_t v;
        v.rstn = r;    v.ifr = ifr;   v.pdb = pdb;   v.pdr = pdr;
        v.pdpc = pdpc; v.exv = exv;   v.exw = exw;   v.ext = ext;
        v.excv = excv; v.excpc = excpc; v.idr = idr;
        v.e_v = ev;    v.e_pc = epc;  v.e_fl = efl;  v.e_qv = eqv;
        v.e_qpc = eqpc; v.e_qb = eqb; v.e_qr = eqr;  v.e_qt = eqt;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rstn     = v.rstn;
        ifReady  = v.ifr;
        pdBranch = v.pdb;
        pdReason = v.pdr;
        pdPC     = v.pdpc;
        exVld    = v.exv;
        exWrong  = v.exw;
        exPCTar  = v.ext;
        excVld   = v.excv;
        excPC    = v.excpc;
        idReady  = v.idr;
    endtask

    task automatic chk_row(input int i, input vec_t v);
        chk($sformatf("row%0d.ifVld", i), 32'(ifVld), 32'(v.e_v));
        chk($sformatf("row%0d.ifPC", i), ifPC, v.e_pc);
        chk($sformatf("row%0d.flush", i), 32'(flush), 32'(v.e_fl));
        chk($sformatf("row%0d.fqVld", i), 32'(fqVld), 32'(v.e_qv));
        chk($sformatf("row%0d.fqPC", i), fqPC, v.e_qpc);
        chk($sformatf("row%0d.fqBr", i), 32'(fqBranch), 32'(v.e_qb));
        chk($sformatf("row%0d.fqRs", i), 32'(fqReason), 32'(v.e_qr));
        chk($sformatf("row%0d.fqTg", i), fqTarget, v.e_qt);
    endtask

    task automatic quiet();
        rstn = 1; ifReady = 0; pdBranch = 0; pdReason = 0; pdPC = 0;
        exVld = 0; exWrong = 0; exPCTar = 0; excVld = 0; excPC = 0;
        idReady = 0;
    endtask

    localparam logic [31:0] A0 = 32'h1C000000;
    localparam logic [31:0] T1 = 32'h1C000100;
    localparam logic [31:0] X4 = 32'h1C000400;
    localparam logic [31:0] E8 = 32'h1C008000;
    localparam logic [31:0] FF = 32'hFFFFFFF8;

    initial begin
        // Rows: inputs, then expected outputs after the following edge.
        tbl.push_back(mk(1,1,0,0,0, 0,0,0, 0,0, 1,  1,A0,0, 0,0,0,0,0));
        tbl.push_back(mk(1,1,0,0,0, 0,0,0, 0,0, 1,
                         1,32'h1C000008,0, 1,A0,0,0,0));
        tbl.push_back(mk(1,1,1,1,T1, 0,0,0, 0,0, 1,
                         1,T1,0, 1,32'h1C000008,1,1,T1));
        tbl.push_back(mk(1,1,0,0,0, 0,0,0, 0,0, 0,
                         1,32'h1C000108,0, 1,32'h1C000008,1,1,T1));
        tbl.push_back(mk(1,1,0,0,0, 0,0,0, 0,0, 0,
                         1,32'h1C000110,0, 1,32'h1C000008,1,1,T1));
        tbl.push_back(mk(1,1,0,0,0, 0,0,0, 0,0, 0,
                         0,32'h1C000118,0, 1,32'h1C000008,1,1,T1));
        tbl.push_back(mk(1,1,0,0,0, 0,0,0, 0,0, 0,
                         0,32'h1C000118,0, 1,32'h1C000008,1,1,T1));
        tbl.push_back(mk(1,1,0,0,0, 0,0,0, 0,0, 1,
                         1,32'h1C000118,0, 1,T1,0,0,0));
        tbl.push_back(mk(1,1,0,0,0, 0,0,0, 0,0, 0,
                         0,32'h1C000120,0, 1,T1,0,0,0));
        tbl.push_back(mk(1,1,0,0,0, 0,0,0, 0,0, 1,
                         1,32'h1C000120,0, 1,32'h1C000108,0,0,0));
        tbl.push_back(mk(1,1,0,0,0, 1,1,32'h1C000203, 0,0, 1,
                         1,32'h1C000200,1, 0,0,0,0,0));
        tbl.push_back(mk(1,1,0,0,0, 1,1,X4, 1,E8, 1,
                         1,E8,1, 0,0,0,0,0));
        tbl.push_back(mk(1,1,0,0,0, 0,0,0, 0,0, 0,
                         1,32'h1C008008,0, 1,E8,0,0,0));
        tbl.push_back(mk(1,1,0,0,0, 1,0,X4, 0,0, 0,
                         1,32'h1C008010,0, 1,E8,0,0,0));
        tbl.push_back(mk(1,0,0,0,0, 0,0,0, 0,0, 0,
                         1,32'h1C008010,0, 1,E8,0,0,0));
        tbl.push_back(mk(1,1,0,0,0, 0,1,X4, 0,0, 0,
                         1,32'h1C008018,0, 1,E8,0,0,0));
        tbl.push_back(mk(1,1,0,0,0, 0,0,0, 0,0, 0,
                         0,32'h1C008020,0, 1,E8,0,0,0));
        tbl.push_back(mk(0,1,0,0,0, 0,0,0, 0,0, 0,  0,A0,0, 0,0,0,0,0));
        tbl.push_back(mk(1,1,0,0,0, 1,1,X4, 0,0, 1,  1,A0,0, 0,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,0, 0,0,0, 0,0, 0,  0,A0,0, 0,0,0,0,0));
        tbl.push_back(mk(1,1,0,0,0, 0,0,0, 1,32'h1C00ABCE, 0,
                         1,32'h1C00ABCC,1, 0,0,0,0,0));
        tbl.push_back(mk(1,1,1,0,FF, 0,0,0, 0,0, 0,
                         1,FF,0, 1,32'h1C00ABCC,1,0,FF));
        tbl.push_back(mk(1,1,0,0,0, 0,0,0, 0,0, 1,
                         1,32'h0,0, 1,FF,0,0,0));
        tbl.push_back(mk(1,1,0,0,0, 0,0,0, 0,0, 1,
                         1,32'h8,0, 1,32'h0,0,0,0));

        // Reset state.
        quiet();
        rstn = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst.ifVld", 32'(ifVld), 32'h0);
        chk("rst.ifPC", ifPC, RST_PC);
        chk("rst.flush", 32'(flush), 32'h0);
        chk("rst.fqVld", 32'(fqVld), 32'h0);
        chk("rst.fqPC", fqPC, 32'h0);
        chk("rst.fqBr", 32'(fqBranch), 32'h0);
        chk("rst.fqRs", 32'(fqReason), 32'h0);
        chk("rst.fqTg", fqTarget, 32'h0);

        // Directed table; the model tracks along for the random phase.
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            tick();
            chk_row(i, tbl[i]);
        end

        // Random stimulus against the reference model.
        for (int c = 0; c < 4000; c++) begin
            rstn     = ($urandom_range(0, 199) != 0);
            ifReady  = ($urandom_range(0, 99) < 75);
            pdBranch = ($urandom_range(0, 99) < 25);
            pdReason = 1'($urandom_range(0, 1));
            pdPC     = $urandom();
            exVld    = ($urandom_range(0, 99) < 20);
            exWrong  = ($urandom_range(0, 99) < 30);
            exPCTar  = $urandom();
            excVld   = ($urandom_range(0, 99) < 2);
            excPC    = $urandom();
            idReady  = ($urandom_range(0, 99) < 45);
            tick();
            chk_model(c);
        end

        // Fill the queue, then drop reset between edges.
        quiet();
        ifReady = 1;
        repeat (7) begin
            tick();
            chk_model(9999);
        end
        chk("full.fqVld", 32'(fqVld), 32'h1);
        chk("full.ifVld", 32'(ifVld), 32'h0);
        #3;
        rstn = 0;
        #1;
        chk("arst.fqVld", 32'(fqVld), 32'h0);
        chk("arst.ifVld", 32'(ifVld), 32'h0);
        chk("arst.ifPC", ifPC, RST_PC);
        chk("arst.flush", 32'(flush), 32'h0);
        chk("arst.fqPC", fqPC, 32'h0);
        chk("arst.fqTg", fqTarget, 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rstn = 1;
        tick();
        chk_model(10000);
        tick();
        chk_model(10001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
